// File: rtl/token_decimation_arbiter.sv
// token_decimation_arbiter: round-robin share of one decimating token lane between N_REQ requesters
// Ports:
//   i_clk, i_rst_n             clock (rising edge), asynchronous active-low reset
//   i_en                       arbitration enable, sampled at the clock edge (IDLE <-> RUN)
//   i_req  / o_gnt             level requests / one-hot combinational grant
//   i_cfg_valid / o_cfg_ready  ratio write handshake (ready is always 1)
//   i_cfg_id, i_cfg_ratio      requester to reprogram and its new ratio K
//   o_out_token, o_out_id      registered forwarded-token pulse and its source id
//   o_busy                     FSM is in RUN
//   o_drop_cnt                 saturating dropped-token count, only with TOKEN_DROP_CNT_EN defined
module token_decimation_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [ID_W-1:0]  i_cfg_id,
  input  logic [CNT_W-1:0] i_cfg_ratio,
`ifdef TOKEN_DROP_CNT_EN
  output logic [15:0]      o_drop_cnt,
`endif
  output logic             o_out_token,
  output logic [ID_W-1:0]  o_out_id,
  output logic             o_busy
);
  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_rr, w_gid;
  logic [CNT_W-1:0] r_ratio [N_REQ];
  logic [CNT_W-1:0] r_cnt [N_REQ];
  logic [CNT_W-1:0] w_k, w_c;
  logic [N_REQ-1:0] w_elig;
  logic             w_hit, w_fwd, w_cfg_ok;

  assign o_cfg_ready = 1'b1;
  assign o_busy      = r_state == S_RUN;
  assign w_cfg_ok    = i_cfg_valid && int'(i_cfg_id) < N_REQ;

  always_comb begin
    w_state_nxt = i_en ? S_RUN : S_IDLE;
  end

  // the requester being reconfigured sits out this cycle so its count never sees a stale ratio
  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      w_elig[i] = i_req[i] && !(w_cfg_ok && int'(i_cfg_id) == i);
  end

  always_comb begin
    w_hit = 1'b0;
    w_gid = '0;
    for (int k = 0; k < N_REQ; k++)
      if (!w_hit && r_state == S_RUN && w_elig[(int'(r_rr) + k) % N_REQ]) begin
        w_hit = 1'b1;
        w_gid = ID_W'((int'(r_rr) + k) % N_REQ);
      end
  end

  assign o_gnt = w_hit ? (N_REQ'(1) << w_gid) : '0;
  assign w_k   = r_ratio[w_gid];
  assign w_c   = r_cnt[w_gid];
  // K=0 never forwards, K=1 always, K>=2 on the K-th token
  assign w_fwd = w_hit && (w_k == CNT_W'(1) || (w_k >= CNT_W'(2) && w_c == w_k - CNT_W'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      o_out_token <= 1'b0;
      o_out_id    <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_ratio[i] <= CNT_W'(2);
        r_cnt[i]   <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      o_out_token <= w_fwd;
      if (w_fwd) o_out_id <= w_gid;
      if (w_hit) begin
        r_rr <= (int'(w_gid) == N_REQ - 1) ? '0 : w_gid + ID_W'(1);
        if (w_k != '0) r_cnt[w_gid] <= w_fwd ? '0 : w_c + CNT_W'(1);
      end
      if (w_cfg_ok) begin
        r_ratio[i_cfg_id] <= i_cfg_ratio;
        r_cnt[i_cfg_id]   <= '0;
      end
    end
  end

`ifdef TOKEN_DROP_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_drop_cnt <= '0;
    else if (w_cfg_ok) o_drop_cnt <= '0;
    else if (w_hit && !w_fwd && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_token_decimation_arbiter.sv
// tb_token_decimation_arbiter: reference-model and directed-vector bench for token_decimation_arbiter
module tb_token_decimation_arbiter;
  localparam int N = 4;
  logic       clk = 0, rst_n = 0, en = 0, cfg_valid = 0;
  logic [3:0] req = '0, cfg_ratio = '0, gnt;
  logic [1:0] cfg_id = '0, out_id;
  logic       cfg_ready, out_token, busy;
`ifdef TOKEN_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  int nvec = 0, nerr = 0;
  int m_ratio [N], m_cnt [N];
  int m_rr, m_id, m_drop;
  bit m_run, m_tok;

  always #5 clk = ~clk;

  token_decimation_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req(req), .o_gnt(gnt),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_id(cfg_id), .i_cfg_ratio(cfg_ratio),
`ifdef TOKEN_DROP_CNT_EN
    .o_drop_cnt(drop_cnt),
`endif
    .o_out_token(out_token), .o_out_id(out_id), .o_busy(busy)
  );

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // who must win now: first requester at or after the pointer that is not being configured
  function automatic int eg();
    if (!m_run) return -1;
    for (int k = 0; k < N; k++) begin
      int j = (m_rr + k) % N;
      if (req[j] && !(cfg_valid && int'(cfg_id) == j)) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_ratio[i] = 2;
        m_cnt[i] = 0;
      end
      m_rr = 0; m_run = 0; m_tok = 0; m_id = 0; m_drop = 0;
    end else begin : upd
      int g;
      g = eg();
      m_tok = 0;
      if (g >= 0) begin
        m_rr = (g + 1) % N;
        if (m_ratio[g] == 1) m_tok = 1;
        else if (m_ratio[g] >= 2) begin
          m_cnt[g]++;
          if (m_cnt[g] == m_ratio[g]) begin
            m_cnt[g] = 0;
            m_tok = 1;
          end
        end
        if (m_tok) m_id = g;
        else if (m_drop < 65535) m_drop++;
      end
      if (cfg_valid && int'(cfg_id) < N) begin
        m_ratio[cfg_id] = int'(cfg_ratio);
        m_cnt[cfg_id] = 0;
        m_drop = 0;
      end
      m_run = en;
    end
  end

  always @(negedge clk) begin : cmp
    int g;
    g = eg();
    chk("gnt", int'(gnt), g < 0 ? 0 : (1 << g));
    chk("out_token", int'(out_token), int'(m_tok));
    if (m_tok) chk("out_id", int'(out_id), m_id);
    chk("busy", int'(busy), int'(m_run));
    chk("cfg_ready", int'(cfg_ready), 1);
`ifdef TOKEN_DROP_CNT_EN
    chk("drop_cnt", int'(drop_cnt), m_drop);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int id, int k);
    cfg_valid = 1;
    cfg_id = 2'(id);
    cfg_ratio = 4'(k);
    tick();
    cfg_valid = 0;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1;
    chk("rst_tok", int'(out_token), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_id", int'(out_id), 0);
    // default ratio 2 halves a lone requester's stream
    en = 1; req = 4'b0001;
    tick();
    for (int i = 0; i <= 8; i++) begin
      #3;
      if (i < 8) chk("t1_gnt", int'(gnt), 1);
      chk("t1_tok", int'(out_token), int'(i > 0 && i % 2 == 0));
      if (out_token) chk("t1_id", int'(out_id), 0);
      tick();
    end
    req = '0;
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < N; i++) wr(i, 1);
    req = 4'b1111;
    for (int i = 0; i <= 8; i++) begin
      #3;
      if (i < 8) chk("t2_gnt", int'(gnt), 1 << (i % 4));
      if (i > 0) begin
        chk("t2_tok", int'(out_token), 1);
        chk("t2_id", int'(out_id), (i - 1) % 4);
      end
      tick();
    end
    // ratio 3 on id 2; the write cycle itself masks id 2
    req = 4'b0100; cfg_valid = 1; cfg_id = 2; cfg_ratio = 3;
    #3;
    chk("t3_mask", int'(gnt), 0);
    tick();
    cfg_valid = 0;
    for (int i = 0; i <= 9; i++) begin
      #3;
      if (i < 9) chk("t3_gnt", int'(gnt), 4);
      chk("t3_tok", int'(out_token), int'(i == 3 || i == 6 || i == 9));
      tick();
    end
    req = '0;
    wr(1, 0);
    req = 4'b0010;
    for (int i = 0; i <= 5; i++) begin
      #3;
      if (i < 5) chk("t4_gnt", int'(gnt), 2);
      chk("t4_tok", int'(out_token), 0);
`ifdef TOKEN_DROP_CNT_EN
      if (i == 5) chk("t4_drop", int'(drop_cnt), 5);
`endif
      tick();
    end
    req = 4'b1000;
    tick();
    en = 0; req = '0;
    tick();
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("t5_gnt", int'(gnt), 0);
      chk("t5_busy", int'(busy), 0);
      tick();
    end
    en = 1;
    #3;
    chk("t5_idle", int'(gnt), 0);
    tick();
    #3;
    chk("t5_first", int'(gnt), 1);
    tick();
    // reset lands between edges while a forwarded token is on the lane
    chk("t6_pre_tok", int'(out_token), 1);
    #2;
    rst_n = 0;
    #1;
    chk("t6_tok", int'(out_token), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_gnt", int'(gnt), 0);
    tick();
    rst_n = 1; req = 4'b0001;
    tick();
    for (int i = 0; i <= 2; i++) begin
      #3;
      chk("t6_gnt_run", int'(gnt), 1);
      chk("t6_tok_run", int'(out_token), int'(i == 2));
      tick();
    end
    req = '0; en = 0;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
